ustc_line_pack: RTL and testbench
=================================

# ustc_line_pack

Producer for the unstructured sparse tensor core partial-sum path. It accepts one dense column stream, IN_W elements per beat, and drops zero elements. Each surviving element is packed into a DW_LINE-bit line `{ctrl, row, data}`. Lines fill NUM_IN output lanes in order. One lane-vector beat goes out per column, or several when a column overflows the lanes. The output bus feeds `ustc_psum` (`in`, `col`) directly, with a valid/ready handshake added on the upstream side.

## Interface
Parameters:
- M, 16: rows per column (elements per dense column).
- IN_W, 4: dense elements per input beat. Must divide M. Must satisfy IN_W ≤ NUM_IN.
- NUM_IN, 32: output lanes per beat.
- DW_DATA, 8: element width.
- DW_ROW, 4: row-index width. Must satisfy 2^DW_ROW ≥ M.
- DW_COL, 4: column-index width.
- DW_CTRL, 4: control-field width.
- DW_LINE, DW_DATA+DW_ROW+DW_CTRL: line width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  dense beat valid.
- in_ready  output  1  dense beat accepted when in_valid & in_ready.
- in_data  input  IN_W*DW_DATA  dense elements; element k sits at bits [k*DW_DATA +: DW_DATA].
- in_col  input  DW_COL  column index; sampled on the first beat of a column.
- in_last  input  1  final beat of the column.
- out_valid  output  1  packed beat valid.
- out_ready  input  1  downstream accepts the beat.
- out  output  NUM_IN*DW_LINE  lane vector; lane 0 at the LSBs.
- out_col  output  DW_COL  column index for the beat; drives `ustc_psum.col`.
- out_last  output  1  beat closes its column.

## Operation
- Line format, occupied lane: `{ctrl=4'h7, row, data}`. Unused lanes are all-zero (16'h0000 at default widths).
- row = row_base + k, where row_base is the count of elements already accepted in the current column. row_base steps by IN_W per accepted beat and returns to 0 after an in_last beat.
- Within a beat, nonzero elements go to lanes fill, fill+1, … in ascending k. fill is the current lane occupancy.
- State FILL:
  - nz = count of nonzero elements in in_data.
  - in_ready = (fill + nz ≤ NUM_IN). in_ready may depend combinationally on in_valid and in_data.
  - On accept without in_last: lanes written, fill += nz, remain in FILL.
  - On accept with in_last: lanes written, out_last = 1, go to HOLD.
  - When in_valid is high and the beat does not fit (overflow): no accept, out_last = 0, go to HOLD. The pending beat is retried after drain.
- State HOLD:
  - out_valid = 1 and in_ready = 0.
  - out, out_col and out_last are stable until out_ready.
  - On out_ready: clear all lanes, fill = 0, return to FILL. row_base is kept on an overflow flush and is 0 after a last flush.
- out_col holds the in_col latched at the first accepted beat of the column. in_col changes mid-column are ignored.
- All-zero column: the in_last beat still yields a beat with all lanes zero and out_last = 1, unless the Configuration option below is defined.
- Zero test is exact equality of DW_DATA bits to 0.

## Timing
- Reset values:
  - out_valid = 0, out = 0, out_col = 0, out_last = 0.
  - State = FILL, fill = 0, row_base = 0.
  - in_ready follows the FILL rule once reset is released.
- Latency: an in_last beat accepted at edge t gives out_valid high after edge t; the beat is visible in cycle t+1.
- A beat that fits is accepted in the same cycle it is presented.
- HOLD exits on the edge where out_ready = 1. in_ready returns the following cycle. Minimum cost is one dead input cycle per output beat.
- out_ready while out_valid = 0 has no effect.
- Reset mid-column or mid-HOLD discards the partial buffer and any pending beat. No output beat is produced.
- Throughput at defaults: M/IN_W + 1 cycles per column (4 input beats + 1 output cycle).

## Configuration
- `USTC_PACK_DROP_EMPTY_EN`
  - Defined: when an in_last beat is accepted and fill remains 0 after it, no beat is emitted. State returns to FILL and row_base resets.
  - Undefined: an all-zero beat with out_last = 1 is always emitted.
  - Overflow flushes are unaffected, because they are never empty.

## Test plan
- Defaults, col 3, nonzeros row1=0x01, row6=0x02, row10=0x03, row14=0x04, 4 beats -> one beat: lanes 0..3 = 16'h7101, 16'h7602, 16'h7A03, 16'h7E04, other lanes 0, out_col=3, out_last=1, out_valid one cycle after the last accept.
- Same column with out_ready held low 5 cycles -> out stable, in_ready=0 throughout; next column accepted the cycle after the handshake.
- Override NUM_IN=4, column of 16 nonzero values 0x01..0x10 -> 4 beats with out_last=0,0,0,1; beat 2 lane 0 = 16'h7405.
- All-zero column, col 5 -> without macro: beat with all lanes 0, out_col=5, out_last=1; with `USTC_PACK_DROP_EMPTY_EN`: no out_valid.
- Assert rst after 2 of 4 beats, then send a fresh column with row0=0x09 -> lane 0 = 16'h7009, which confirms row_base was reset and no stale lanes remain.
- Back-to-back columns 0..15 with random zero density and random out_ready -> every nonzero appears exactly once with the correct row and out_col, and out_last appears once per column.

Source files
------------

// File: rtl/ustc_line_pack.sv
`default_nettype none
// ============================================================================
// Module   : ustc_line_pack
// Purpose  : Packs a dense column stream into sparse lines for ustc_psum.
//            Accepts IN_W dense elements per beat, drops zero elements and
//            writes each survivor as a line {ctrl, row, data} into the next
//            free lane of an NUM_IN-lane output vector. A lane vector is
//            emitted when the column ends (out_last = 1) or when the next
//            beat would overflow the lanes (out_last = 0).
// Ports    :
//   clk, rst        clock, asynchronous active-high reset
//   in_valid        dense beat valid
//   in_ready        dense beat accepted (in_valid & in_ready)
//   in_data         IN_W elements, element k at [k*DW_DATA +: DW_DATA]
//   in_col          column index, sampled on the first beat of a column
//   in_last         final beat of the column
//   out_valid       packed lane vector valid
//   out_ready       downstream accepts the lane vector
//   out             NUM_IN lines, lane 0 at the LSBs
//   out_col         column index of the emitted vector
//   out_last        emitted vector closes its column
// Options  : define USTC_PACK_DROP_EMPTY_EN to suppress the output beat of
//            a column that carried no nonzero elements.
// Revision : 1.0 - initial release
// ============================================================================
module ustc_line_pack #(
  parameter int M       = 16,
  parameter int IN_W    = 4,
  parameter int NUM_IN  = 32,
  parameter int DW_DATA = 8,
  parameter int DW_ROW  = 4,
  parameter int DW_COL  = 4,
  parameter int DW_CTRL = 4,
  parameter int DW_LINE = DW_DATA + DW_ROW + DW_CTRL
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IN_W*DW_DATA-1:0]   in_data,
  input  logic [DW_COL-1:0]         in_col,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_IN*DW_LINE-1:0] out,
  output logic [DW_COL-1:0]         out_col,
  output logic                      out_last
);

  // Lane occupancy runs 0..NUM_IN inclusive, nonzero count 0..IN_W.
  localparam int FW  = $clog2(NUM_IN + 1);
  localparam int NZW = $clog2(IN_W + 1);

  localparam logic [DW_CTRL-1:0] CTRL_OCC = DW_CTRL'(7);
  localparam logic [DW_ROW-1:0]  ROW_STEP = DW_ROW'(IN_W);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t                    state, state_nxt;
  logic [NUM_IN*DW_LINE-1:0] lanes, lanes_nxt, placed;
  logic [FW-1:0]             fill, fill_nxt, fill_sum;
  logic [DW_ROW-1:0]         row_base, row_nxt;
  logic [DW_COL-1:0]         col_q, col_nxt;
  logic                      last_q, last_nxt;
  logic [NZW-1:0]            nz;
  logic                      fits;
  int                        slot;
  int                        sum_i;

  // --------------------------------------------------------------------------
  // Beat analysis: count nonzero elements and build the lane image that
  // results if the current beat is accepted. Survivors land in consecutive
  // lanes starting at the current occupancy, in ascending element order.
  // The slot < NUM_IN guard only matters for beats that do not fit, whose
  // image is discarded anyway.
  // --------------------------------------------------------------------------
  always_comb begin
    nz     = '0;
    placed = lanes;
    slot   = int'(fill);
    for (int k = 0; k < IN_W; k++) begin
      if (in_data[k*DW_DATA +: DW_DATA] != '0) begin
        nz = nz + NZW'(1);
        if (slot < NUM_IN) begin
          placed[slot*DW_LINE +: DW_LINE] =
            {CTRL_OCC, row_base + DW_ROW'(k), in_data[k*DW_DATA +: DW_DATA]};
        end
        slot = slot + 1;
      end
    end
    sum_i    = int'(fill) + int'(nz);
    fits     = (sum_i <= NUM_IN);
    fill_sum = FW'(sum_i);
  end

  // --------------------------------------------------------------------------
  // Next-state and handshake logic.
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    lanes_nxt = lanes;
    fill_nxt  = fill;
    row_nxt   = row_base;
    col_nxt   = col_q;
    last_nxt  = last_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state)
      FILL: begin
        // Readiness depends on the presented beat: it is accepted only if
        // all of its nonzero elements fit into the remaining lanes.
        in_ready = fits;
        if (in_valid && fits) begin
          lanes_nxt = placed;
          fill_nxt  = fill_sum;
          // row_base is zero exactly on the first beat of a column.
          if (row_base == '0) begin
            col_nxt = in_col;
          end
          if (in_last) begin
            row_nxt = '0;
`ifdef USTC_PACK_DROP_EMPTY_EN
            if (fill_sum == '0) begin
              state_nxt = FILL;
              last_nxt  = 1'b0;
            end else begin
              state_nxt = HOLD;
              last_nxt  = 1'b1;
            end
`else
            state_nxt = HOLD;
            last_nxt  = 1'b1;
`endif
          end else begin
            row_nxt = row_base + ROW_STEP;
          end
        end else if (in_valid) begin
          // Overflow: flush what we have, the beat is retried after drain.
          state_nxt = HOLD;
          last_nxt  = 1'b0;
        end
      end

      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          lanes_nxt = '0;
          fill_nxt  = '0;
          last_nxt  = 1'b0;
          state_nxt = FILL;
        end
      end

      default: begin
        state_nxt = FILL;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FILL;
      lanes    <= '0;
      fill     <= '0;
      row_base <= '0;
      col_q    <= '0;
      last_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      lanes    <= lanes_nxt;
      fill     <= fill_nxt;
      row_base <= row_nxt;
      col_q    <= col_nxt;
      last_q   <= last_nxt;
    end
  end

  assign out      = lanes;
  assign out_col  = col_q;
  assign out_last = last_q;

endmodule

`default_nettype wire

// File: tb/tb_ustc_line_pack.sv
`default_nettype none
// ============================================================================
// Module   : tb_ustc_line_pack
// Purpose  : Self-checking bench for ustc_line_pack. Uses NUM_IN = 4 so that
//            lane overflow occurs regularly. Expected output beats come from
//            a queue-based model of the packing rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ustc_line_pack;

  localparam int M       = 16;
  localparam int IN_W    = 4;
  localparam int NUM_IN  = 4;
  localparam int DW_DATA = 8;
  localparam int DW_ROW  = 4;
  localparam int DW_COL  = 4;
  localparam int DW_CTRL = 4;
  localparam int DW_LINE = DW_DATA + DW_ROW + DW_CTRL;
  localparam int OW      = NUM_IN * DW_LINE;
  localparam int BEATS   = M / IN_W;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [IN_W*DW_DATA-1:0] in_data = '0;
  logic [DW_COL-1:0]       in_col = '0;
  logic                    in_last = 1'b0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic [OW-1:0]           out;
  logic [DW_COL-1:0]       out_col;
  logic                    out_last;

  ustc_line_pack #(
    .M(M), .IN_W(IN_W), .NUM_IN(NUM_IN), .DW_DATA(DW_DATA),
    .DW_ROW(DW_ROW), .DW_COL(DW_COL), .DW_CTRL(DW_CTRL), .DW_LINE(DW_LINE)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_col(in_col), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .out_col(out_col), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [OW-1:0]     lines;
    logic [DW_COL-1:0] col;
    logic              last;
  } beat_t;

  logic [DW_LINE-1:0] cur_q[$];
  beat_t              exp_q[$];
  beat_t              seen_q[$];
  int                 m_row = 0;
  logic [DW_COL-1:0]  m_col = '0;
  logic               rand_rdy = 1'b0;

  function automatic void emit(input logic last);
    beat_t         bt;
    logic [OW-1:0] v;
    v = '0;
    foreach (cur_q[i]) v[i*DW_LINE +: DW_LINE] = cur_q[i];
    bt.lines = v;
    bt.col   = m_col;
    bt.last  = last;
    exp_q.push_back(bt);
    cur_q.delete();
  endfunction

  // Called when a beat is first presented: any overflow flush precedes it.
  function automatic void model_beat(input logic [IN_W*DW_DATA-1:0] data,
                                     input logic [DW_COL-1:0] col, input logic last);
    logic [DW_LINE-1:0] nzl[$];
    logic [DW_DATA-1:0] b;
    for (int k = 0; k < IN_W; k++) begin
      b = data[k*DW_DATA +: DW_DATA];
      if (b != 0) nzl.push_back({4'h7, 4'(m_row + k), b});
    end
    if (m_row == 0) m_col = col;
    if (cur_q.size() + nzl.size() > NUM_IN) emit(1'b0);
    foreach (nzl[i]) cur_q.push_back(nzl[i]);
    m_row += IN_W;
    if (last) begin
      m_row = 0;
`ifdef USTC_PACK_DROP_EMPTY_EN
      if (cur_q.size() != 0) emit(1'b1);
`else
      emit(1'b1);
`endif
    end
  endfunction

  // ---------------- output monitor ----------------
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      beat_t e;
      beat_t s;
      s.lines = out; s.col = out_col; s.last = out_last;
      seen_q.push_back(s);
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 64'(exp_q.size()), 64'd1);
      end else begin
        e = exp_q.pop_front();
        check("beat_lines", 64'(out), 64'(e.lines));
        check("beat_col", 64'(out_col), 64'(e.col));
        check("beat_last", 64'(out_last), 64'(e.last));
      end
    end
  end

  // Random downstream backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cur_q.delete(); exp_q.delete(); seen_q.delete();
    m_row = 0; m_col = '0;
  endtask

  task automatic send_beat(input logic [IN_W*DW_DATA-1:0] data,
                           input logic [DW_COL-1:0] col, input logic last);
    int n;
    model_beat(data, col, last);
    in_valid = 1'b1; in_data = data; in_col = col; in_last = last;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_col(input logic [DW_COL-1:0] col, input logic [M*DW_DATA-1:0] vals);
    for (int b = 0; b < BEATS; b++)
      send_beat(vals[b*IN_W*DW_DATA +: IN_W*DW_DATA], col, (b == BEATS-1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [M*DW_DATA-1:0] v;
    logic [OW-1:0]        held;
    logic [3:0]           lasts;
    int                   dens;
    int                   nlast;

    do_reset();
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out", 64'(out), 64'd0);
    check("rst_out_col", 64'(out_col), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Column 3, four sparse nonzeros, downstream stalled for 5 cycles.
    v = '0;
    v[1*8 +: 8] = 8'h01; v[6*8 +: 8] = 8'h02; v[10*8 +: 8] = 8'h03; v[14*8 +: 8] = 8'h04;
    out_ready = 1'b0;
    for (int b = 0; b < BEATS - 1; b++)
      send_beat(v[b*32 +: 32], 4'd3, 1'b0);
    check("pre_last_out_valid", 64'(out_valid), 64'd0);
    send_beat(v[3*32 +: 32], 4'd3, 1'b1);
    check("latency_out_valid", 64'(out_valid), 64'd1);
    check("col3_lines", 64'(out), 64'h7E04_7A03_7602_7101);
    check("col3_out_col", 64'(out_col), 64'd3);
    check("col3_out_last", 64'(out_last), 64'd1);
    held = out;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_stable", 64'(out), 64'(held));
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("hs_cycle_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    check("after_hs_in_ready", 64'(in_ready), 64'd1);
    check("after_hs_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;

    // Dense column 0x01..0x10: overflows into four beats.
    seen_q.delete();
    for (int r = 0; r < M; r++) v[r*8 +: 8] = 8'(r + 1);
    send_col(4'd9, v);
    drain();
    check("dense_beats", 64'(seen_q.size()), 64'd4);
    if (seen_q.size() == 4) begin
      lasts = {seen_q[0].last, seen_q[1].last, seen_q[2].last, seen_q[3].last};
      check("dense_last_seq", 64'(lasts), 64'b0001);
      check("dense_b2_lane0", 64'(seen_q[1].lines[15:0]), 64'h7405);
      check("dense_b2_col", 64'(seen_q[1].col), 64'd9);
    end

    // All-zero column 5.
    seen_q.delete();
    send_col(4'd5, '0);
    drain();
`ifdef USTC_PACK_DROP_EMPTY_EN
    check("empty_beats", 64'(seen_q.size()), 64'd0);
`else
    check("empty_beats", 64'(seen_q.size()), 64'd1);
    if (seen_q.size() == 1) begin
      check("empty_lines", 64'(seen_q[0].lines), 64'd0);
      check("empty_col", 64'(seen_q[0].col), 64'd5);
      check("empty_last", 64'(seen_q[0].last), 64'd1);
    end
`endif

    // Reset after two beats, then a fresh column with row0 = 0x09.
    send_beat(32'h0100_0000, 4'd7, 1'b0);
    send_beat(32'h0000_0200, 4'd7, 1'b0);
    do_reset();
    out_ready = 1'b1;
    v = '0; v[7:0] = 8'h09;
    send_col(4'd2, v);
    drain();
    check("post_rst_beats", 64'(seen_q.size()), 64'd1);
    if (seen_q.size() == 1) begin
      check("post_rst_lines", 64'(seen_q[0].lines), 64'h7009);
      check("post_rst_col", 64'(seen_q[0].col), 64'd2);
    end

    // Back-to-back random columns 0..15 with random backpressure.
    seen_q.delete();
    rand_rdy = 1'b1;
    for (int c = 0; c < 16; c++) begin
      dens = $urandom_range(0, 100);
      for (int r = 0; r < M; r++)
        v[r*8 +: 8] = ($urandom_range(0, 99) < dens) ? 8'($urandom_range(1, 255)) : 8'h00;
      send_col(4'(c), v);
    end
    drain();
    rand_rdy = 1'b0;
    #1 out_ready = 1'b1;
    nlast = 0;
    foreach (seen_q[i]) if (seen_q[i].last) nlast++;
`ifdef USTC_PACK_DROP_EMPTY_EN
    check("rand_last_count_max", 64'(nlast <= 16), 64'd1);
`else
    check("rand_last_count", 64'(nlast), 64'd16);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
